fifo_param: RTL and testbench

- Parametrised single-clock synchronous FIFO; next generation of the team's 16x8 FIFO.
- Adds configurable width and depth.
- Adds selectable standard or first-word-fall-through (FWFT) read mode.
- Adds programmable almost-full/almost-empty levels, an occupancy count output and a synchronous flush.
- Sits between producer and consumer logic in the same clock domain; connects through the team's FIFO interface.

---
 rtl/fifo_param_pkg.sv | 21 ++
 rtl/fifo_param_if.sv | 41 ++++
 rtl/fifo_param_mem.sv | 30 +++
 rtl/fifo_param.sv | 118 +++++++++++
 tb/tb_fifo_param.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_param_pkg.sv
// Shared types and constants for the parameterised FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: read-mode enum, default geometry, width helper for the occupancy count.
package fifo_param_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    // count must represent 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_param_if.sv
// Handshake/status bundle between a producer/consumer pair and the FIFO.
// Latency: n/a (wires only).
// Backpressure: producer watches full/wr_ack/overflow, consumer watches empty/underflow.
//
// master: drives flush, wr_en, data_in, rd_en; observes data and status.
// slave : the FIFO side, mirror image of master.
interface fifo_param_if
    import fifo_param_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
);
    localparam int CW = cnt_width(DEPTH);

    logic             flush;
    logic             wr_en;
    logic [WIDTH-1:0] data_in;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             wr_ack;
    logic             overflow;
    logic             underflow;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;

    modport master (
        output flush, wr_en, data_in, rd_en,
        input  data_out, wr_ack, overflow, underflow,
               full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  flush, wr_en, data_in, rd_en,
        output data_out, wr_ack, overflow, underflow,
               full, empty, almost_full, almost_empty, count
    );

endinterface

// File: rtl/fifo_param_mem.sv
// Dual-port storage array: synchronous write, asynchronous read address.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller qualifies wr_en.
//
// Ports: clk, wr_en/wr_addr/wr_data (write port), rd_addr -> rd_data (read port).
module fifo_mem_dp #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are deliberately not reset; pointers/count define validity.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO, configurable width/depth, standard or first-word-fall-through read.
// Latency: STD data_out 1 cycle after accepted rd_en; FWFT head word visible 1 cycle after write.
// Backpressure: writes refused when full (overflow pulse), reads refused when empty (underflow pulse).
//
// Ports: clk, rst_n (async, active low), bus (fifo_param_if.slave: flush, wr_en, data_in, rd_en,
//        data_out, wr_ack, overflow, underflow, full, empty, almost_full, almost_empty, count).
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int         FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter fifo_mode_e MODE       = FIFO_STD,
    parameter int         AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int         AE_LEVEL   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_param_if.slave   bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = cnt_width(FIFO_DEPTH);

    // Elaboration-time parameter sanity.
    if (FIFO_WIDTH < 1 || FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_geom
        $error("fifo_param: FIFO_WIDTH must be >=1 and FIFO_DEPTH a power of two >=2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH || AE_LEVEL < 0 || AE_LEVEL >= FIFO_DEPTH) begin : g_bad_lvl
        $error("fifo_param: AF_LEVEL or AE_LEVEL out of range");
    end

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [FIFO_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  wr_ack_q;
    logic                  overflow_q;
    logic                  underflow_q;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // flush suppresses both ports for its cycle.
    assign wr_accept = bus.wr_en && !full  && !bus.flush;
    assign rd_accept = bus.rd_en && !empty && !bus.flush;

    fifo_mem_dp #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (bus.data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
            if (rd_accept) rd_ptr <= rd_ptr + AW'(1);
            if (wr_accept && !rd_accept) begin
                count_q <= count_q + CW'(1);
            end else if (rd_accept && !wr_accept) begin
                count_q <= count_q - CW'(1);
            end
            wr_ack_q    <= wr_accept;
            overflow_q  <= bus.wr_en && full;
            underflow_q <= bus.rd_en && empty;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word is presented directly; forced to zero when nothing is stored.
        assign bus.data_out = empty ? '0 : rd_data;
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] data_q;
        // Loads only on an accepted pop; holds through rejected reads and flush.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (rd_accept) begin
                data_q <= rd_data;
            end
        end
        assign bus.data_out = data_q;
    end

    assign bus.wr_ack       = wr_ack_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: STD, FWFT and custom-threshold instances on one clock.
module tb_fifo_param;
    import fifo_param_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    fifo_param_if #(.WIDTH(16), .DEPTH(8)) if_std  ();
    fifo_param_if #(.WIDTH(16), .DEPTH(8)) if_fwft ();
    fifo_param_if #(.WIDTH(16), .DEPTH(8)) if_thr  ();

    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .MODE(FIFO_STD),
                 .AF_LEVEL(7), .AE_LEVEL(1))
        u_std  (.clk(clk), .rst_n(rst_n), .bus(if_std));
    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .MODE(FIFO_FWFT),
                 .AF_LEVEL(7), .AE_LEVEL(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(if_fwft));
    fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .MODE(FIFO_STD),
                 .AF_LEVEL(6), .AE_LEVEL(2))
        u_thr  (.clk(clk), .rst_n(rst_n), .bus(if_thr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [15:0] dout;
        logic        ack;
        logic        ovf;
        logic        udf;
        logic        full;
        logic        empty;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] din,
                                input logic [15:0] dout, input logic ack, input logic ovf,
                                input logic udf, input logic full, input logic empty,
                                input logic [3:0] cnt);
        vec_t v;
        v.wr = wr; v.rd = rd; v.din = din; v.dout = dout; v.ack = ack;
        v.ovf = ovf; v.udf = udf; v.full = full; v.empty = empty; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        if_std.flush  = 0; if_std.wr_en  = 0; if_std.rd_en  = 0; if_std.data_in  = '0;
        if_fwft.flush = 0; if_fwft.wr_en = 0; if_fwft.rd_en = 0; if_fwft.data_in = '0;
        if_thr.flush  = 0; if_thr.wr_en  = 0; if_thr.rd_en  = 0; if_thr.data_in  = '0;

        // ---- reset state ----
        #3;
        chk("rst.count", 32'(if_std.count), 0);
        chk("rst.empty", 32'(if_std.empty), 1);
        chk("rst.aempty", 32'(if_std.almost_empty), 1);
        chk("rst.full", 32'(if_std.full), 0);
        chk("rst.afull", 32'(if_std.almost_full), 0);
        chk("rst.dout", 32'(if_std.data_out), 0);
        chk("rst.ack", 32'(if_std.wr_ack), 0);
        chk("rst.ovf", 32'(if_std.overflow), 0);
        chk("rst.udf", 32'(if_std.underflow), 0);
        chk("rst.fwft_dout", 32'(if_fwft.data_out), 0);
        step();
        rst_n = 1'b1;

        // ---- STD table: fill, overflow, full wr+rd, drain, empty wr+rd, underflow ----
        for (int i = 1; i <= 8; i++)
            vt.push_back(mk(1, 0, 16'(i), 16'h0000, 1, 0, 0, (i == 8), 0, 4'(i)));
        vt.push_back(mk(1, 0, 16'h0099, 16'h0000, 0, 1, 0, 1, 0, 4'd8));
        vt.push_back(mk(1, 1, 16'h0AAA, 16'h0001, 0, 1, 0, 0, 0, 4'd7));
        for (int k = 2; k <= 8; k++)
            vt.push_back(mk(0, 1, 16'h0000, 16'(k), 0, 0, 0, 0, (k == 8), 4'(8 - k)));
        vt.push_back(mk(1, 1, 16'h0BBB, 16'h0008, 1, 0, 1, 0, 0, 4'd1));
        vt.push_back(mk(0, 1, 16'h0000, 16'h0BBB, 0, 0, 0, 0, 1, 4'd0));
        vt.push_back(mk(0, 1, 16'h0000, 16'h0BBB, 0, 0, 1, 0, 1, 4'd0));
        vt.push_back(mk(0, 0, 16'h0000, 16'h0BBB, 0, 0, 0, 0, 1, 4'd0));

        for (int i = 0; i < vt.size(); i++) begin
            if_std.wr_en   = vt[i].wr;
            if_std.rd_en   = vt[i].rd;
            if_std.data_in = vt[i].din;
            step();
            chk($sformatf("vec%0d.dout", i),  32'(if_std.data_out),  32'(vt[i].dout));
            chk($sformatf("vec%0d.ack", i),   32'(if_std.wr_ack),    32'(vt[i].ack));
            chk($sformatf("vec%0d.ovf", i),   32'(if_std.overflow),  32'(vt[i].ovf));
            chk($sformatf("vec%0d.udf", i),   32'(if_std.underflow), 32'(vt[i].udf));
            chk($sformatf("vec%0d.full", i),  32'(if_std.full),      32'(vt[i].full));
            chk($sformatf("vec%0d.empty", i), 32'(if_std.empty),     32'(vt[i].empty));
            chk($sformatf("vec%0d.count", i), 32'(if_std.count),     32'(vt[i].cnt));
        end
        if_std.wr_en = 0;
        if_std.rd_en = 0;

        // ---- steady state at count=4, pointers wrap several times ----
        for (int i = 0; i < 4; i++) begin
            if_std.wr_en = 1; if_std.data_in = 16'(16'h0100 + i);
            step();
        end
        chk("stream.pre_count", 32'(if_std.count), 4);
        for (int c = 0; c < 20; c++) begin
            if_std.wr_en = 1; if_std.rd_en = 1; if_std.data_in = 16'(16'h0104 + c);
            step();
            chk($sformatf("stream%0d.count", c), 32'(if_std.count), 4);
            chk($sformatf("stream%0d.dout", c), 32'(if_std.data_out), 32'(16'h0100 + c));
        end
        if_std.rd_en = 0;

        // ---- flush at count=5 together with a write ----
        if_std.wr_en = 1; if_std.data_in = 16'h0200;
        step();
        chk("flush.pre_count", 32'(if_std.count), 5);
        if_std.flush = 1; if_std.data_in = 16'h0201;
        step();
        if_std.flush = 0; if_std.wr_en = 0;
        chk("flush.count", 32'(if_std.count), 0);
        chk("flush.empty", 32'(if_std.empty), 1);
        chk("flush.ack", 32'(if_std.wr_ack), 0);
        chk("flush.dout_hold", 32'(if_std.data_out), 32'h0113);

        // ---- FWFT ----
        if_fwft.wr_en = 1; if_fwft.data_in = 16'hABCD;
        step();
        if_fwft.wr_en = 0;
        chk("fwft.dout", 32'(if_fwft.data_out), 32'hABCD);
        chk("fwft.empty0", 32'(if_fwft.empty), 0);
        step();
        chk("fwft.dout_hold", 32'(if_fwft.data_out), 32'hABCD);
        if_fwft.rd_en = 1;
        step();
        if_fwft.rd_en = 0;
        chk("fwft.empty1", 32'(if_fwft.empty), 1);
        chk("fwft.dout_zero", 32'(if_fwft.data_out), 0);
        if_fwft.wr_en = 1; if_fwft.data_in = 16'h1234;
        step();
        if_fwft.wr_en = 0;
        chk("fwft.dout2", 32'(if_fwft.data_out), 32'h1234);
        if_fwft.flush = 1;
        step();
        if_fwft.flush = 0;
        chk("fwft.flush_dout", 32'(if_fwft.data_out), 0);
        chk("fwft.flush_empty", 32'(if_fwft.empty), 1);

        // ---- thresholds AF=6, AE=2 ----
        begin
            logic ae_tab [6];
            logic af_tab [6];
            ae_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            af_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            for (int i = 0; i < 6; i++) begin
                if_thr.wr_en = 1; if_thr.data_in = 16'(i);
                step();
                chk($sformatf("thr%0d.count", i + 1), 32'(if_thr.count), 32'(i + 1));
                chk($sformatf("thr%0d.aempty", i + 1), 32'(if_thr.almost_empty), 32'(ae_tab[i]));
                chk($sformatf("thr%0d.afull", i + 1), 32'(if_thr.almost_full), 32'(af_tab[i]));
                chk($sformatf("thr%0d.full", i + 1), 32'(if_thr.full), 0);
            end
            if_thr.wr_en = 0;
        end

        // ---- async reset mid-burst ----
        for (int i = 0; i < 3; i++) begin
            if_std.wr_en = 1; if_std.data_in = 16'(16'h0300 + i);
            step();
        end
        chk("arst.pre_ack", 32'(if_std.wr_ack), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.count", 32'(if_std.count), 0);
        chk("arst.empty", 32'(if_std.empty), 1);
        chk("arst.aempty", 32'(if_std.almost_empty), 1);
        chk("arst.full", 32'(if_std.full), 0);
        chk("arst.ack", 32'(if_std.wr_ack), 0);
        chk("arst.dout", 32'(if_std.data_out), 0);
        chk("arst.thr_count", 32'(if_thr.count), 0);
        if_std.wr_en = 0;
        #1;
        rst_n = 1'b1;
        if_std.wr_en = 1; if_std.data_in = 16'h5555;
        step();
        if_std.wr_en = 0; if_std.rd_en = 1;
        chk("arst.post_ack", 32'(if_std.wr_ack), 1);
        step();
        if_std.rd_en = 0;
        chk("arst.post_dout", 32'(if_std.data_out), 32'h5555);
        chk("arst.post_count", 32'(if_std.count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
